// File: rtl/memory_cycle.sv
// memory_cycle: M-stage data memory plus M/W register; define SUBWORD_ACCESS_EN for B/H/BU/HU accesses.
// Latency: load data 1 cycle M->W. Backpressure: StallM holds W and suppresses the store.
module memory_cycle #(
  parameter int DMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        regwriteM,
  input  logic        MemWriteM,
  input  logic        ResultSrcM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALU_ResultM,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  RD_M,
  input  logic [31:0] PCPlus4M,
  input  logic        StallM,
  input  logic        FlushW,
  output logic        regwriteW,
  output logic        ResultSrcW,
  output logic [4:0]  RD_W,
  output logic [31:0] PCPlus4W,
  output logic [31:0] ALU_ResultW,
  output logic [31:0] ReadDataW,
  output logic        MisalignW
);

  localparam int AW = $clog2(DMEM_WORDS);

  logic [31:0]   mem [DMEM_WORDS];
  logic [AW-1:0] idx;
  logic [31:0]   rd_word;
  logic          misalign;
  logic [31:0]   load_data;
  logic [31:0]   wr_data;
  logic [3:0]    wr_mask;

  // Upper address bits are dropped so the memory aliases modulo its size.
  assign idx     = ALU_ResultM[AW+1:2];
  assign rd_word = mem[idx];

`ifdef SUBWORD_ACCESS_EN
  logic [1:0]  ofs;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    ofs       = ALU_ResultM[1:0];
    rd_byte   = rd_word[8*ofs +: 8];
    rd_half   = ofs[1] ? rd_word[31:16] : rd_word[15:0];
    misalign  = 1'b0;
    load_data = rd_word;
    wr_data   = WriteDataM;
    wr_mask   = 4'hF;
    case (funct3M)
      3'b000, 3'b100: begin
        load_data = funct3M[2] ? {24'b0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
        wr_data   = {4{WriteDataM[7:0]}};
        wr_mask   = 4'b0001 << ofs;
      end
      3'b001, 3'b101: begin
        misalign  = ofs[0];
        load_data = funct3M[2] ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
        wr_data   = {2{WriteDataM[15:0]}};
        wr_mask   = ofs[1] ? 4'b1100 : 4'b0011;
      end
      // Unlisted encodings behave as full-word accesses.
      default: misalign = (ofs != 2'b00);
    endcase
  end
`else
  logic unused_funct3;

  assign unused_funct3 = ^funct3M;
  assign misalign      = 1'b0;
  assign load_data     = rd_word;
  assign wr_data       = WriteDataM;
  assign wr_mask       = 4'hF;
`endif

  // A flush does not cancel the store; only a stall or misalignment does.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DMEM_WORDS; i++) mem[i] <= '0;
    end else if (MemWriteM && !StallM && !misalign) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_mask[b]) mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || FlushW) begin
      regwriteW   <= 1'b0;
      ResultSrcW  <= 1'b0;
      RD_W        <= '0;
      PCPlus4W    <= '0;
      ALU_ResultW <= '0;
      ReadDataW   <= '0;
      MisalignW   <= 1'b0;
    end else if (!StallM) begin
      regwriteW   <= regwriteM;
      ResultSrcW  <= ResultSrcM;
      RD_W        <= RD_M;
      PCPlus4W    <= PCPlus4M;
      ALU_ResultW <= ALU_ResultM;
      ReadDataW   <= (ResultSrcM && !misalign) ? load_data : '0;
      MisalignW   <= (MemWriteM || ResultSrcM) && misalign;
    end
  end

endmodule

// File: tb/tb_memory_cycle.sv
// Randomized bench for memory_cycle against a word-array model of the memory and W register.
module tb_memory_cycle;
  localparam int DW = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b0, regwriteM = 1'b0, MemWriteM = 1'b0, ResultSrcM = 1'b0;
  logic [2:0]  funct3M = 3'b010;
  logic [31:0] ALU_ResultM = '0, WriteDataM = '0, PCPlus4M = '0;
  logic [4:0]  RD_M = '0;
  logic        StallM = 1'b0, FlushW = 1'b0;
  logic        regwriteW, ResultSrcW, MisalignW;
  logic [4:0]  RD_W;
  logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW;

  memory_cycle #(.DMEM_WORDS(DW)) dut (
    .clk(clk), .reset(reset), .regwriteM(regwriteM), .MemWriteM(MemWriteM),
    .ResultSrcM(ResultSrcM), .funct3M(funct3M), .ALU_ResultM(ALU_ResultM),
    .WriteDataM(WriteDataM), .RD_M(RD_M), .PCPlus4M(PCPlus4M), .StallM(StallM),
    .FlushW(FlushW), .regwriteW(regwriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W),
    .PCPlus4W(PCPlus4W), .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW),
    .MisalignW(MisalignW)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] mm [DW];
  logic        exp_rw, exp_rs, exp_mis;
  logic [4:0]  exp_rd;
  logic [31:0] exp_pc, exp_alu, exp_rdata;

`ifdef SUBWORD_ACCESS_EN
  localparam bit SUB = 1'b1;
`else
  localparam bit SUB = 1'b0;
`endif

  function automatic bit f_mis(input logic [2:0] f3, input logic [31:0] a);
    if (!SUB) return 1'b0;
    if (f3 == 3'd0 || f3 == 3'd4) return 1'b0;
    if (f3 == 3'd1 || f3 == 3'd5) return (a % 2) != 0;
    return (a % 4) != 0;
  endfunction

  function automatic logic [31:0] f_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] w, b, h;
    w = mm[(a >> 2) % DW];
    b = (w >> (8 * (a % 4))) & 32'hFF;
    h = (w >> (16 * ((a >> 1) % 2))) & 32'hFFFF;
    if (!SUB) return w;
    case (f3)
      3'd0: return (b >= 128) ? b + 32'hFFFFFF00 : b;
      3'd4: return b;
      3'd1: return (h >= 32768) ? h + 32'hFFFF0000 : h;
      3'd5: return h;
      default: return w;
    endcase
  endfunction

  task automatic f_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int i;
    int sh;
    i = (a >> 2) % DW;
    if (SUB && (f3 == 3'd0 || f3 == 3'd4)) begin
      sh = 8 * (a % 4);
      mm[i] = (mm[i] & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
    end else if (SUB && (f3 == 3'd1 || f3 == 3'd5)) begin
      sh = 16 * ((a >> 1) % 2);
      mm[i] = (mm[i] & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
    end else begin
      mm[i] = wd;
    end
  endtask

  // Drive one M-stage cycle, advance the model, and return #1 after the edge.
  task automatic apply(input bit rst, input bit rw, input bit mw, input bit rs,
                       input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       input logic [4:0] rd, input logic [31:0] pc, input bit st, input bit fl);
    bit mis;
    reset = rst; regwriteM = rw; MemWriteM = mw; ResultSrcM = rs; funct3M = f3;
    ALU_ResultM = a; WriteDataM = wd; RD_M = rd; PCPlus4M = pc; StallM = st; FlushW = fl;
    mis = f_mis(f3, a);
    if (rst || fl) begin
      exp_rw = 0; exp_rs = 0; exp_rd = 0; exp_pc = 0; exp_alu = 0; exp_rdata = 0; exp_mis = 0;
    end else if (!st) begin
      exp_rw = rw; exp_rs = rs; exp_rd = rd; exp_pc = pc; exp_alu = a;
      exp_rdata = (rs && !mis) ? f_load(f3, a) : 32'h0;
      exp_mis = (mw || rs) && mis;
    end
    if (rst) begin
      for (int i = 0; i < DW; i++) mm[i] = 32'h0;
    end else if (mw && !st && !mis) begin
      f_store(f3, a, wd);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic op(input bit mw, input bit rs, input logic [2:0] f3, input logic [31:0] a,
                    input logic [31:0] wd);
    apply(0, rs, mw, rs, f3, a, wd, 5'($urandom_range(1, 31)), $urandom, 0, 0);
  endtask

  task automatic test_reset();
    apply(1, 1, 1, 1, 3'b010, 32'h08, 32'h12345678, 5'd3, 32'h40, 0, 0);
    checks++; if (regwriteW !== 1'b0) begin errors++; $display("FAIL reset_regwrite: got %b want 0", regwriteW); end
    checks++; if (ResultSrcW !== 1'b0) begin errors++; $display("FAIL reset_resultsrc: got %b want 0", ResultSrcW); end
    checks++; if (RD_W !== 5'd0) begin errors++; $display("FAIL reset_rd: got %h want 0", RD_W); end
    checks++; if (PCPlus4W !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", PCPlus4W); end
    checks++; if (ALU_ResultW !== 32'h0) begin errors++; $display("FAIL reset_alu: got %h want 0", ALU_ResultW); end
    checks++; if (ReadDataW !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", ReadDataW); end
    checks++; if (MisalignW !== 1'b0) begin errors++; $display("FAIL reset_mis: got %b want 0", MisalignW); end
    op(0, 1, 3'b010, 32'h08, 0);
    checks++; if (ReadDataW !== 32'h0) begin errors++; $display("FAIL reset_store_discard: got %h want 0", ReadDataW); end
  endtask

  task automatic test_word_access();
    op(1, 0, 3'b010, 32'h10, 32'hDEADBEEF);
    op(0, 1, 3'b010, 32'h10, 0);
    checks++; if (ReadDataW !== 32'hDEADBEEF) begin errors++; $display("FAIL word_load: got %h want deadbeef", ReadDataW); end
    checks++; if (RD_W !== exp_rd || regwriteW !== 1'b1 || ResultSrcW !== 1'b1) begin
      errors++; $display("FAIL word_ctrl: rd=%h rw=%b rs=%b want rd=%h rw=1 rs=1", RD_W, regwriteW, ResultSrcW, exp_rd);
    end
  endtask

  task automatic test_stall_flush();
    op(1, 0, 3'b010, 32'h20, 32'h13572468);
    apply(0, 1, 0, 0, 3'b010, 32'h55, 0, 5'd9, 32'h104, 0, 0);
    apply(0, 0, 1, 0, 3'b010, 32'h20, 32'hAAAA5555, 5'd2, 32'h200, 1, 0);
    checks++; if (regwriteW !== 1'b1 || RD_W !== 5'd9) begin errors++; $display("FAIL stall_hold_ctrl: rw=%b rd=%h want rw=1 rd=09", regwriteW, RD_W); end
    checks++; if (ALU_ResultW !== 32'h55 || PCPlus4W !== 32'h104) begin errors++; $display("FAIL stall_hold_data: alu=%h pc=%h want 55/104", ALU_ResultW, PCPlus4W); end
    op(0, 1, 3'b010, 32'h20, 0);
    checks++; if (ReadDataW !== 32'h13572468) begin errors++; $display("FAIL stall_store_suppressed: got %h want 13572468", ReadDataW); end
    apply(0, 1, 0, 0, 3'b010, 32'h66, 0, 5'd7, 32'h300, 0, 1);
    checks++; if (regwriteW !== 1'b0 || RD_W !== 5'd0 || PCPlus4W !== 32'h0) begin
      errors++; $display("FAIL flush_bubble: rw=%b rd=%h pc=%h want 0/0/0", regwriteW, RD_W, PCPlus4W);
    end
    apply(0, 0, 1, 0, 3'b010, 32'h24, 32'h0BADCAFE, 5'd0, 32'h0, 0, 1);
    op(0, 1, 3'b010, 32'h24, 0);
    checks++; if (ReadDataW !== 32'h0BADCAFE) begin errors++; $display("FAIL flush_store_executes: got %h want 0badcafe", ReadDataW); end
  endtask

  task automatic test_same_cycle();
    op(1, 0, 3'b010, 32'h30, 32'h22222222);
    apply(0, 1, 1, 1, 3'b010, 32'h30, 32'h11111111, 5'd4, 32'h8, 0, 0);
    checks++; if (ReadDataW !== 32'h22222222) begin errors++; $display("FAIL read_old_data: got %h want 22222222", ReadDataW); end
    op(0, 1, 3'b010, 32'h130, 0);
    checks++; if (ReadDataW !== 32'h11111111) begin errors++; $display("FAIL alias_load: got %h want 11111111", ReadDataW); end
  endtask

  task automatic test_reset_clear();
    op(1, 0, 3'b010, 32'h04, 32'hCAFEF00D);
    apply(1, 1, 1, 0, 3'b010, 32'h0C, 32'h77777777, 5'd5, 32'h44, 0, 0);
    checks++; if (regwriteW !== 1'b0 || ALU_ResultW !== 32'h0 || PCPlus4W !== 32'h0) begin
      errors++; $display("FAIL reset_pulse_outputs: rw=%b alu=%h pc=%h want 0", regwriteW, ALU_ResultW, PCPlus4W);
    end
    op(0, 1, 3'b010, 32'h04, 0);
    checks++; if (ReadDataW !== 32'h0) begin errors++; $display("FAIL reset_clears_mem: got %h want 0", ReadDataW); end
    op(0, 1, 3'b010, 32'h0C, 0);
    checks++; if (ReadDataW !== 32'h0) begin errors++; $display("FAIL reset_discards_store: got %h want 0", ReadDataW); end
  endtask

`ifdef SUBWORD_ACCESS_EN
  task automatic test_subword();
    op(1, 0, 3'b010, 32'h10, 32'h000080F0);
    op(0, 1, 3'b000, 32'h10, 0);
    checks++; if (ReadDataW !== 32'hFFFFFFF0) begin errors++; $display("FAIL lb: got %h want fffffff0", ReadDataW); end
    op(0, 1, 3'b100, 32'h10, 0);
    checks++; if (ReadDataW !== 32'h000000F0) begin errors++; $display("FAIL lbu: got %h want 000000f0", ReadDataW); end
    op(0, 1, 3'b001, 32'h10, 0);
    checks++; if (ReadDataW !== 32'hFFFF80F0) begin errors++; $display("FAIL lh: got %h want ffff80f0", ReadDataW); end
    op(0, 1, 3'b101, 32'h10, 0);
    checks++; if (ReadDataW !== 32'h000080F0) begin errors++; $display("FAIL lhu: got %h want 000080f0", ReadDataW); end
    op(1, 0, 3'b010, 32'h11, 32'h12345678);
    checks++; if (MisalignW !== 1'b1) begin errors++; $display("FAIL sw_misalign: got %b want 1", MisalignW); end
    op(0, 1, 3'b010, 32'h10, 0);
    checks++; if (ReadDataW !== 32'h000080F0) begin errors++; $display("FAIL sw_misalign_nowrite: got %h want 000080f0", ReadDataW); end
    op(0, 1, 3'b010, 32'h12, 0);
    checks++; if (ReadDataW !== 32'h0 || MisalignW !== 1'b1) begin errors++; $display("FAIL lw_misalign: rdata=%h mis=%b want 0/1", ReadDataW, MisalignW); end
  endtask
`endif

  task automatic test_random();
    bit mw, rs, st, fl;
    for (int n = 0; n < 400; n++) begin
      mw = ($urandom_range(0, 2) == 0);
      rs = ($urandom_range(0, 1) == 0);
      st = ($urandom_range(0, 7) == 0);
      fl = ($urandom_range(0, 9) == 0);
      apply(0, 1'($urandom), mw, rs, 3'($urandom), $urandom, $urandom,
            5'($urandom), $urandom, st, fl);
      checks++; if (regwriteW !== exp_rw) begin errors++; $display("FAIL rnd_regwrite[%0d]: got %b want %b", n, regwriteW, exp_rw); end
      checks++; if (ResultSrcW !== exp_rs) begin errors++; $display("FAIL rnd_resultsrc[%0d]: got %b want %b", n, ResultSrcW, exp_rs); end
      checks++; if (RD_W !== exp_rd) begin errors++; $display("FAIL rnd_rd[%0d]: got %h want %h", n, RD_W, exp_rd); end
      checks++; if (PCPlus4W !== exp_pc) begin errors++; $display("FAIL rnd_pc[%0d]: got %h want %h", n, PCPlus4W, exp_pc); end
      checks++; if (ALU_ResultW !== exp_alu) begin errors++; $display("FAIL rnd_alu[%0d]: got %h want %h", n, ALU_ResultW, exp_alu); end
      checks++; if (ReadDataW !== exp_rdata) begin errors++; $display("FAIL rnd_rdata[%0d]: got %h want %h", n, ReadDataW, exp_rdata); end
      checks++; if (MisalignW !== exp_mis) begin errors++; $display("FAIL rnd_mis[%0d]: got %b want %b", n, MisalignW, exp_mis); end
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_word_access();
    test_stall_flush();
    test_same_cycle();
    test_reset_clear();
`ifdef SUBWORD_ACCESS_EN
    test_subword();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
